// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: combinational ALU feeding a 2-entry
// output/skid register pair behind valid/ready handshakes.
module alu_exec_stage #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             illegal,
   output logic [TAG_W-1:0] out_tag
);

   typedef enum logic [2:0] {
      OP_NONE = 3'b000,
      OP_ADD  = 3'b001,
      OP_SUB  = 3'b010,
      OP_SLT  = 3'b011,
      OP_AND  = 3'b100,
      OP_OR   = 3'b101,
      OP_XOR  = 3'b110,
      OP_NOR  = 3'b111
   } op_e;

   op_e              op;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             add_ovf;
   logic             sub_ovf;
   logic             less;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;
   logic             alu_ill;
   logic             alu_zero;

   assign op = op_e'(alu_control);

   always_comb begin
      sum      = src_a + src_b;
      diff     = src_a - src_b;
      add_ovf  = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
      sub_ovf  = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
      // Native signed compare stays correct where the sign of a-b would not.
      less     = $signed(src_a) < $signed(src_b);
      alu_res  = '0;
      alu_ovf  = 1'b0;
      alu_ill  = 1'b0;
      unique case (op)
         OP_NONE: alu_ill = 1'b1;
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = add_ovf;
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = sub_ovf;
         end
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, less};
         OP_AND:  alu_res = src_a & src_b;
         OP_OR:   alu_res = src_a | src_b;
         OP_XOR:  alu_res = src_a ^ src_b;
         OP_NOR:  alu_res = ~(src_a | src_b);
         default: alu_res = '0;
      endcase
      alu_zero = (alu_res == '0);
   end

   logic             skid_valid;
   logic [WIDTH-1:0] skid_result;
   logic             skid_zero;
   logic             skid_overflow;
   logic             skid_illegal;
   logic [TAG_W-1:0] skid_tag;

   logic accept;
   logic pop;
   logic skid_next;

   always_comb begin
      accept    = in_valid & in_ready;
      pop       = out_valid & out_ready;
      skid_next = skid_valid ? !pop : (accept & out_valid & !pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid     <= 1'b0;
         in_ready      <= 1'b1;
         result        <= '0;
         zero          <= 1'b0;
         overflow      <= 1'b0;
         illegal       <= 1'b0;
         out_tag       <= '0;
         skid_valid    <= 1'b0;
         skid_result   <= '0;
         skid_zero     <= 1'b0;
         skid_overflow <= 1'b0;
         skid_illegal  <= 1'b0;
         skid_tag      <= '0;
      end else begin
         // in_ready is low whenever SKID is valid, so a drain never races an accept.
         if (pop && skid_valid) begin
            result   <= skid_result;
            zero     <= skid_zero;
            overflow <= skid_overflow;
            illegal  <= skid_illegal;
            out_tag  <= skid_tag;
         end else if (accept && (!out_valid || pop)) begin
            result    <= alu_res;
            zero      <= alu_zero;
            overflow  <= alu_ovf;
            illegal   <= alu_ill;
            out_tag   <= in_tag;
            out_valid <= 1'b1;
         end else if (accept) begin
            skid_result   <= alu_res;
            skid_zero     <= alu_zero;
            skid_overflow <= alu_ovf;
            skid_illegal  <= alu_ill;
            skid_tag      <= in_tag;
         end else if (pop) begin
            out_valid <= 1'b0;
         end
         skid_valid <= skid_next;
         in_ready   <= !skid_next;
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: depth-2 FIFO reference model with a per-cycle
// compare process, directed literal pins, random traffic and mid-flight reset.
module tb_alu_exec_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  alu_control;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        overflow;
   logic        illegal;
   logic [4:0]  out_tag;

   alu_exec_stage #(.WIDTH(32), .TAG_W(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .alu_control(alu_control), .src_a(src_a), .src_b(src_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
      .overflow(overflow), .illegal(illegal), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic        ovf;
      logic        ill;
      logic [4:0]  tag;
   } ent_t;

   int   checks = 0;
   int   errors = 0;
   ent_t q[$];
   ent_t lit[int];
   bit   lit_on = 1'b1;
   bit   live = 1'b0;
   bit   just_reset = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference: 64-bit signed arithmetic; overflow means the true value does not fit in 32 bits.
   function automatic ent_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] t);
      ent_t        e;
      longint      sa;
      longint      sb;
      longint      r;
      logic [31:0] lo;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e.ovf = 1'b0;
      e.ill = 1'b0;
      e.tag = t;
      e.res = 32'd0;
      case (op)
         3'd0: e.ill = 1'b1;
         3'd1, 3'd2: begin
            r = (op == 3'd1) ? sa + sb : sa - sb;
            lo = r[31:0];
            e.res = lo;
            e.ovf = (r != longint'($signed(lo)));
         end
         3'd3: e.res = (sa < sb) ? 32'd1 : 32'd0;
         3'd4: e.res = a & b;
         3'd5: e.res = a | b;
         3'd6: e.res = a ^ b;
         default: e.res = ~(a | b);
      endcase
      e.zero = (e.res == 32'd0);
      return e;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         live <= 1'b1;
         just_reset <= 1'b1;
      end else if (live) begin
         int  n;
         bit  do_pop;
         bit  do_acc;
         n = q.size();
         do_pop = (n > 0) && out_ready;
         do_acc = in_valid && (n < 2);
         if (do_pop) void'(q.pop_front());
         if (do_acc) q.push_back(model(alu_control, src_a, src_b, in_tag));
         just_reset <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (live) begin
         chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
         chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
         if (just_reset) begin
            chk("rst_result", {32'd0, result}, 64'd0);
            chk("rst_flags", {60'd0, zero, overflow, illegal, 1'b0}, 64'd0);
            chk("rst_tag", {59'd0, out_tag}, 64'd0);
         end
         if (q.size() > 0) begin
            chk("result", {32'd0, result}, {32'd0, q[0].res});
            chk("zero", {63'd0, zero}, {63'd0, q[0].zero});
            chk("overflow", {63'd0, overflow}, {63'd0, q[0].ovf});
            chk("illegal", {63'd0, illegal}, {63'd0, q[0].ill});
            chk("out_tag", {59'd0, out_tag}, {59'd0, q[0].tag});
            if (lit_on && lit.exists(int'(out_tag))) begin
               chk("lit_result", {32'd0, result}, {32'd0, lit[int'(out_tag)].res});
               chk("lit_flags", {61'd0, zero, overflow, illegal},
                   {61'd0, lit[int'(out_tag)].zero, lit[int'(out_tag)].ovf, lit[int'(out_tag)].ill});
            end
         end
      end
   end

   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
      int n = 0;
      in_valid = 1'b1;
      alu_control = op;
      src_a = a;
      src_b = b;
      in_tag = t;
      while (!in_ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual=in_ready_low required=accept t=%0t", $time);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      src_a = $urandom;
      src_b = $urandom;
      alu_control = 3'($urandom);
   endtask

   task automatic lsend(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, input logic [31:0] r, input logic z,
                        input logic v, input logic il);
      ent_t e;
      e.res = r;
      e.zero = z;
      e.ovf = v;
      e.ill = il;
      e.tag = t;
      lit[int'(t)] = e;
      send(op, a, b, t);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom % 6)
         0: return 32'h0000_0000;
         1: return 32'h7FFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int acc;
      int cyc;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      alu_control = 3'd0;
      src_a = '0;
      src_b = '0;
      in_tag = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // back-to-back with out_ready high
      lsend(3'd1, 32'd5, 32'd7, 5'd1, 32'd12, 1'b0, 1'b0, 1'b0);
      lsend(3'd2, 32'd3, 32'd5, 5'd2, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      lsend(3'd3, 32'hFFFF_FFFF, 32'd1, 5'd3, 32'd1, 1'b0, 1'b0, 1'b0);
      lsend(3'd7, 32'd0, 32'd0, 5'd4, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      lsend(3'd1, 32'h7FFF_FFFF, 32'd1, 5'd5, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      lsend(3'd2, 32'h8000_0000, 32'd1, 5'd6, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
      lsend(3'd3, 32'h8000_0000, 32'h7FFF_FFFF, 5'd7, 32'd1, 1'b0, 1'b0, 1'b0);
      lsend(3'd2, 32'd9, 32'd9, 5'd8, 32'd0, 1'b1, 1'b0, 1'b0);
      lsend(3'd0, 32'd4, 32'd4, 5'd9, 32'd0, 1'b1, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #1;

      // stall: OUT then SKID fill, third op held upstream
      out_ready = 1'b0;
      lsend(3'd1, 32'd1, 32'd2, 5'd10, 32'd3, 1'b0, 1'b0, 1'b0);
      lsend(3'd6, 32'hF0, 32'hFF, 5'd11, 32'h0F, 1'b0, 1'b0, 1'b0);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      fork
         lsend(3'd5, 32'h100, 32'h1, 5'd12, 32'h101, 1'b0, 1'b0, 1'b0);
         begin
            repeat (4) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      repeat (5) @(posedge clk);
      #1;

      // random traffic
      lit_on = 1'b0;
      acc = 0;
      cyc = 0;
      while (acc < 1000 && cyc < 20000) begin
         in_valid = ($urandom % 3) != 0;
         alu_control = 3'($urandom);
         src_a = pick();
         src_b = pick();
         in_tag = 5'($urandom);
         out_ready = ($urandom % 4) != 0;
         if (in_valid && in_ready) acc++;
         @(posedge clk);
         #1;
         cyc++;
      end
      if (acc < 1000) begin
         checks++;
         errors++;
         $display("FAIL random_timeout actual=%0d required=1000 t=%0t", acc, $time);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // reset with OUT and SKID full, concurrent accept/pop attempt
      out_ready = 1'b0;
      send(3'd1, 32'd10, 32'd20, 5'd21);
      send(3'd4, 32'hFF, 32'h0F, 5'd22);
      rst = 1'b1;
      in_valid = 1'b1;
      alu_control = 3'd1;
      src_a = 32'd1;
      src_b = 32'd1;
      in_tag = 5'd23;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("post_rst_result", {32'd0, result}, 64'd0);
      repeat (6) @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
